// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg: constants shared by the round-robin bus arbiter slice.
// Holds the active-low enable/disable levels, the default master count and
// hold limit, and the reset polarity used by the arbiter registers.
// Optional feature macro used by this slice: BUS_ARB_HOLD_LIMIT_EN.
package bus_arbiter_rr_pkg;

    // Bus handshake lines are active-low: a 0 means "asserted".
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Default sizing for a bus built around this arbiter.
    localparam int BUS_ARB_MASTERS_DEFAULT  = 4;
    localparam int BUS_ARB_MAX_HOLD_DEFAULT = 16;

    // The arbiter reset is synchronous and active-high.
    localparam logic RESET_ACTIVE = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/lock/grant bundle between the bus masters and
// the round-robin arbiter. The slave modport is the arbiter's view, the
// master modport is the view of the masters (or whatever models them).
interface bus_arbiter_rr_if
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N_MASTERS = BUS_ARB_MASTERS_DEFAULT,
    localparam int OWNER_W  = $clog2(N_MASTERS)
);

    logic [N_MASTERS-1:0] mReq_;
    logic [N_MASTERS-1:0] mLock_;
    logic [N_MASTERS-1:0] mGrnt_;
    logic [OWNER_W-1:0]   owner;
    logic                 handoff;

    modport slave (
        input  mReq_,
        input  mLock_,
        output mGrnt_,
        output owner,
        output handoff
    );

    modport master (
        output mReq_,
        output mLock_,
        input  mGrnt_,
        input  owner,
        input  handoff
    );

endinterface

// File: rtl/bus_arbiter_rr_rr_next_picker.sv
// rr_next_picker: combinational rotating scan. Starting just after 'start'
// and wrapping modulo N_MASTERS, returns the first index whose request bit
// is set. The start index itself is never returned as a hit.
module rr_next_picker #(
    parameter int N_MASTERS = 4,
    localparam int OWNER_W  = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]   start,
    output logic                 found,
    output logic [OWNER_W-1:0]   idx
);

    // One extra bit so start+offset never overflows before the wrap.
    localparam logic [OWNER_W:0] N_WIDE = (OWNER_W+1)'(N_MASTERS);

    logic [OWNER_W:0]   sum;
    logic [OWNER_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = start;
        sum   = '0;
        cand  = '0;
        for (int off = N_MASTERS - 1; off >= 1; off--) begin
            sum = {1'b0, start} + (OWNER_W+1)'(off);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            cand = sum[OWNER_W-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: parametrised round-robin arbiter for N bus masters with
// parking on the last owner, one-hot active-low grants, an encoded owner
// index and a one-cycle handoff pulse at the start of each new tenure.
// Optional macro BUS_ARB_HOLD_LIMIT_EN builds a hold counter that forces a
// handoff after MAX_HOLD contended cycles unless the owner holds its lock.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N_MASTERS = BUS_ARB_MASTERS_DEFAULT,
    parameter int MAX_HOLD  = BUS_ARB_MAX_HOLD_DEFAULT,
    localparam int OWNER_W  = $clog2(N_MASTERS)
) (
    input logic             clk,
    input logic             reset,
    bus_arbiter_rr_if.slave bus
);

    logic [N_MASTERS-1:0] req_act;
    logic                 own_req;
    logic                 pick_found;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 force_handoff;
    logic [OWNER_W-1:0]   owner_d, owner_q;
    logic                 handoff_d, handoff_q;
    logic [N_MASTERS-1:0] grnt_n;

    // Convert the active-low requests to active-high and pick out the owner's.
    always_comb begin
        req_act = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_act[i] = (bus.mReq_[i] == ENABLE_);
        end
        own_req = req_act[owner_q];
    end

    rr_next_picker #(
        .N_MASTERS (N_MASTERS)
    ) u_picker (
        .req   (req_act),
        .start (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic              own_lock;
    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;

    // A contended, unlocked owner at the last allowed cycle must give way.
    always_comb begin
        own_lock      = (bus.mLock_[owner_q] == ENABLE_);
        force_handoff = own_req && !own_lock && (hold_cnt_q == HOLD_LAST)
                        && pick_found;
    end

    // Count consecutive requesting cycles of the same owner, saturating.
    always_comb begin
        if ((owner_d != owner_q) || !own_req) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    // Without the hold limit the lock lines and MAX_HOLD have no effect.
    localparam int unused_max_hold = MAX_HOLD;
    logic unused_lock;
    assign unused_lock   = ^bus.mLock_;
    assign force_handoff = 1'b0;
`endif

    // Next owner: forced rotation, then keep a requesting owner, then rotate
    // to the next requester, otherwise park on the current owner.
    always_comb begin
        owner_d = owner_q;
        if (force_handoff) begin
            owner_d = pick_idx;
        end else if (own_req) begin
            owner_d = owner_q;
        end else if (pick_found) begin
            owner_d = pick_idx;
        end
        handoff_d = (owner_d != owner_q);
    end

    // Owner and handoff registers; reset parks the bus on master 0.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            owner_q   <= '0;
            handoff_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            handoff_q <= handoff_d;
        end
    end

    // Exactly one grant line low: the one belonging to the owner.
    always_comb begin
        grnt_n          = {N_MASTERS{DISABLE_}};
        grnt_n[owner_q] = ENABLE_;
    end

    assign bus.mGrnt_  = grnt_n;
    assign bus.owner   = owner_q;
    assign bus.handoff = handoff_q;

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter for N bus masters; the next generation of the four-master fixed-rotation arbiter. It sits between the masters' request lines and the shared bus multiplexers, drives one-hot active-low grants plus an encoded owner index, and parks the bus on the last owner. It adds a bus-lock input and an optional hold-time limit that forces handoff when another master is waiting.

## Interface
- N_MASTERS, 4, number of masters; legal 2..16
- MAX_HOLD, 16, max consecutive grant cycles for an owner under contention; legal ≥2
- OWNER_W, $clog2(N_MASTERS), owner index width (derived, not overridden)
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- mReq_  in  N_MASTERS  per-master bus request, active-low
- mLock_  in  N_MASTERS  per-master lock, active-low; honoured only from the current owner while its request is asserted
- mGrnt_  out  N_MASTERS  one-hot-low grant; exactly one bit low at all times
- owner  out  OWNER_W  index of the current owner
- handoff  out  1  high for exactly the first cycle of a new owner's tenure

## Operation
- State: owner register, holdCnt (only with `BUS_ARB_HOLD_LIMIT_EN`), handoff register.
- mGrnt_ is decoded combinationally from owner: bit[owner]=0, all others 1.
- Next-owner selection at each clk edge, in priority order:
  1. reset=1: owner←0, holdCnt←0, handoff←0.
  2. Forced handoff (macro on only): holdCnt==MAX_HOLD-1, the owner's mReq_ asserted, the owner's mLock_ deasserted, and any other master requesting → owner←first requester scanning owner+1 … owner+N-1, modulo N; the current owner is excluded.
  3. The owner's mReq_ asserted → owner is unchanged.
  4. Otherwise → owner←first requester scanning owner+1 … owner+N-1, modulo N.
  5. No requester → owner is unchanged (parking).
- The scan wraps from N_MASTERS-1 to 0. Index arithmetic is modulo N_MASTERS, not modulo 2^OWNER_W, for non-power-of-two N.
- handoff←1 when owner changes at the edge, else 0.
- holdCnt:
  - ←0 on owner change or when the owner's mReq_ is deasserted.
  - Otherwise increments, saturating at MAX_HOLD-1.
- mLock_ from a non-owner is ignored. The lock suppresses only the forced handoff, never the normal release in rule 4.

## Timing
- Reset values: owner=0; mGrnt_ has only bit0 low (4'b1110 for N=4); handoff=0; holdCnt=0.
- Arbitration latency: a request seen at edge k with the bus released produces a grant after edge k (1 cycle). A parked owner re-requesting needs 0 extra cycles.
- Release: the owner deasserts mReq_ in cycle k. The new grant appears after edge k and the old grant drops in the same cycle (no overlap, no gap).
- Hold limit: an unlocked, contended owner holds at most MAX_HOLD consecutive cycles, then loses the grant at the next edge.
- Simultaneous release and new requests: the rotating scan resolves them in one edge. Starvation-free: every requester is granted within (N_MASTERS-1)·MAX_HOLD+1 cycles when no lock is held.
- Reset asserted mid-tenure: the reset takes effect at the next edge regardless of locks and requests. handoff stays 0 on the reset edge.

## Configuration
- `BUS_ARB_HOLD_LIMIT_EN` defined: holdCnt is built and forced handoff (rule 2) is active. mLock_ suppresses the forced handoff.
- Undefined:
  - No counter; owners hold indefinitely while requesting.
  - mLock_ ports remain but are ignored.
  - MAX_HOLD is unused.
  - Behaviour equals pure round-robin with parking.

## Structure
- Shared header bus.vh holds:
  - the active-low `ENABLE_`/`DISABLE_` constants;
  - `BUS_ARB_MASTERS_DEFAULT` and `BUS_ARB_MAX_HOLD_DEFAULT`;
  - the reset polarity definitions used by this block.
- Sub-module `rr_next_picker` is combinational. It takes the request vector and start index and returns a found flag plus the first requester index after the start, with wrap. It is used for rules 2 and 4.
- Top level holds the owner, holdCnt and handoff registers plus the grant decode.

## Test plan
- Reset, then all mReq_=1111 (N=4): owner=0, mGrnt_=1110, handoff=0 for 10 cycles (parking).
- owner=0; mReq_ changes 1110→0101 (masters 1 and 3 requesting, master 0 released): owner=1 after one edge, handoff pulses for 1 cycle. Master 1 then releases: owner=3 (master 2 skipped).
- owner=3, only master 0 requests: wrap-around gives owner=0 and mGrnt_=1110 one cycle later.
- Macro on, MAX_HOLD=4; master 0 holds while master 2 requests: master 0 is granted exactly 4 cycles, then owner=2 with handoff=1. Repeat with mLock_[0]=0: master 0 is never preempted.
- Macro off, same stimulus: master 0 holds for 50 cycles and owner stays 0.
- Synchronous reset asserted while owner=2 and locked: at the next edge owner=0, mGrnt_=1110, handoff=0.
